// File: rtl/rx_window_sample_buffer.sv
// rx_window_sample_buffer: circular sample window on simple dual-port BRAM, streamed oldest->newest on every trigger.
// Optional build macro RX_BUF_ZERO_PAD_EN: every stream is WINDOW_LENGTH long, leading zeros while the window is filling.
module rx_window_sample_buffer #(
    parameter int DATA_WIDTH    = 16,
    parameter int WINDOW_LENGTH = 510,
    parameter int ADDR_WIDTH    = 9,
    parameter int CNT_WIDTH     = 10
) (
    input  logic                  crx_clk,
    input  logic                  rrx_rst,
    input  logic                  erx_en,
    input  logic                  inew_sample_trig,
    input  logic [DATA_WIDTH-1:0] idata_sample,
    output logic [DATA_WIDTH-1:0] odata_sample,
    output logic                  ovalid,
    output logic                  ofirst,
    output logic                  olast,
    output logic                  obusy,
    output logic                  ooverrun,
    output logic [CNT_WIDTH-1:0]  ofill_count
);
    typedef enum logic {S_IDLE, S_STREAM} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WINDOW_LENGTH - 1);
    localparam logic [CNT_WIDTH-1:0]  FULL      = CNT_WIDTH'(WINDOW_LENGTH);
    localparam logic [CNT_WIDTH-1:0]  ONE       = CNT_WIDTH'(1);

    logic [DATA_WIDTH-1:0] r_mem [0:WINDOW_LENGTH-1];
    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_wr_ptr, r_waddr, r_rd_addr, r_raddr;
    logic [CNT_WIDTH-1:0]  r_fill, r_remain, r_pad;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_we, r_first_pend, r_rvld, r_rfirst, r_rlast, r_rzero, r_ovr_d;

    logic                  w_trig, w_issue, w_last_issue, w_zero;
    logic [CNT_WIDTH-1:0]  w_fill_post, w_len, w_pad_init;
    logic [ADDR_WIDTH-1:0] w_wr_nxt, w_start, w_rd_nxt;

    assign w_trig       = inew_sample_trig && erx_en;
    assign w_fill_post  = (r_fill == FULL) ? FULL : r_fill + ONE;
    assign w_wr_nxt     = (r_wr_ptr == LAST_ADDR) ? '0 : r_wr_ptr + ADDR_WIDTH'(1);
    assign w_start      = (w_fill_post < FULL) ? '0 : w_wr_nxt;
    assign w_rd_nxt     = (r_rd_addr == LAST_ADDR) ? '0 : r_rd_addr + ADDR_WIDTH'(1);
    // A trigger in STREAM restarts instead of issuing, so the aborted stream never reaches olast
    assign w_issue      = (r_state == S_STREAM) && erx_en && !inew_sample_trig;
    assign w_last_issue = w_issue && (r_remain == ONE);
    assign w_zero       = (r_pad != '0);
    assign obusy        = (r_state != S_IDLE);
    assign ofill_count  = r_fill;
`ifdef RX_BUF_ZERO_PAD_EN
    assign w_len      = FULL;
    assign w_pad_init = FULL - w_fill_post;
`else
    assign w_len      = w_fill_post;
    assign w_pad_init = '0;
`endif

    // Next state: a trigger always (re)starts a stream; disable or final issue returns to idle
    always_comb begin
        w_state_nxt = r_state;
        w_state_nxt = w_trig ? S_STREAM : (!erx_en || w_last_issue) ? S_IDLE : r_state;
    end

    // BRAM write port, one cycle after the trigger is accepted
    always_ff @(posedge crx_clk) begin
        if (r_we) r_mem[r_waddr] <= r_wdata;
    end

    // Write staging, pointers, fill tracking, read sequencing and overrun detection
    always_ff @(posedge crx_clk or posedge rrx_rst) begin
        if (rrx_rst) begin
            r_state      <= S_IDLE;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_wr_ptr     <= '0;
            r_fill       <= '0;
            r_rd_addr    <= '0;
            r_remain     <= '0;
            r_pad        <= '0;
            r_first_pend <= 1'b0;
            r_raddr      <= '0;
            r_rvld       <= 1'b0;
            r_rfirst     <= 1'b0;
            r_rlast      <= 1'b0;
            r_rzero      <= 1'b0;
            r_ovr_d      <= 1'b0;
            ooverrun     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_we    <= w_trig;
            if (w_trig) begin
                r_waddr      <= r_wr_ptr;
                r_wdata      <= idata_sample;
                r_wr_ptr     <= w_wr_nxt;
                r_fill       <= w_fill_post;
                r_rd_addr    <= w_start;
                r_remain     <= w_len;
                r_pad        <= w_pad_init;
                r_first_pend <= 1'b1;
            end else if (w_issue) begin
                r_remain     <= r_remain - ONE;
                r_first_pend <= 1'b0;
                if (w_zero) r_pad <= r_pad - ONE;
                else r_rd_addr <= w_rd_nxt;
            end
            r_raddr  <= r_rd_addr;
            r_rvld   <= w_issue;
            r_rfirst <= w_issue && r_first_pend;
            r_rlast  <= w_last_issue;
            r_rzero  <= w_zero;
            r_ovr_d  <= w_trig && (r_state == S_STREAM);
            ooverrun <= r_ovr_d;
        end
    end

    // BRAM read port and output framing; disable suppresses the beat already in flight
    always_ff @(posedge crx_clk or posedge rrx_rst) begin
        if (rrx_rst) begin
            odata_sample <= '0;
            ovalid       <= 1'b0;
            ofirst       <= 1'b0;
            olast        <= 1'b0;
        end else begin
            ovalid <= r_rvld && erx_en;
            ofirst <= r_rfirst && erx_en;
            olast  <= r_rlast && erx_en;
            if (r_rvld && erx_en) odata_sample <= r_rzero ? '0 : r_mem[r_raddr];
        end
    end
endmodule
